stream_mux_rr: RTL and testbench

- Parametrised N:1 datapath multiplexer with a registered output and valid/ready handshake on every channel. Generalises the processor's combinational 2:1, 64-bit mux.
- Supports two selection modes: explicit select, and round-robin arbitration across requesting channels.
- Used wherever several producers share one consumer, e.g. writeback source selection or a shared memory port front-end.
- Provides one cycle of latency and full throughput (one transfer per cycle).

---
 rtl/stream_mux_rr.sv | 139 +++++++++++++
 tb/tb_stream_mux_rr.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/stream_mux_rr.sv
// N:1 valid/ready stream multiplexer with explicit-select and round-robin source choice.
// One cycle latency: a word accepted at an edge is on out_* right after it; full throughput.
// Backpressure: while the held word stalls (out_valid & ~out_ready) every in_ready is low.
module stream_mux_rr #(
  parameter int WIDTH  = 64,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = $clog2(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_IN-1:0]       in_valid,
  output logic [NUM_IN-1:0]       in_ready,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    mode,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_src
);

  // Highest channel index; the pointer parks here so the first RR search starts at 0.
  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_IN - 1);
  // Channel count widened by one bit so range checks and modulo wrap never overflow.
  localparam logic [SEL_W:0]   NUM_IN_X = (SEL_W + 1)'(NUM_IN);

  logic                    out_valid_q, out_valid_d;
  logic [WIDTH-1:0]        out_data_q,  out_data_d;
  logic [SEL_W-1:0]        out_src_q,   out_src_d;
  logic [SEL_W-1:0]        last_grant_q, last_grant_d;

  logic [WIDTH-1:0]        in_word [NUM_IN];
  logic                    sel_hit;
  logic                    rr_found;
  logic [SEL_W-1:0]        rr_idx;
  logic [SEL_W:0]          rr_sum;
  logic [SEL_W-1:0]        rr_cand;
  logic                    grant_vld;
  logic [SEL_W-1:0]        grant;
  logic                    can_accept;
  logic                    in_xfer;

  // View the flat input bus as one word per channel.
  for (genvar i = 0; i < NUM_IN; i++) begin : g_unpack
    assign in_word[i] = in_data[i*WIDTH +: WIDTH];
  end

  // Explicit mode: an out-of-range select never grants, even if the index aliases a valid bit.
  always_comb begin
    sel_hit = 1'b0;
    if ({1'b0, sel} < NUM_IN_X) begin
      sel_hit = in_valid[sel];
    end
  end

  // Round-robin search: first valid channel after last_grant, wrapping modulo NUM_IN.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = '0;
    rr_sum   = '0;
    rr_cand  = '0;
    for (int k = 1; k <= NUM_IN; k++) begin
      rr_sum = {1'b0, last_grant_q} + (SEL_W + 1)'(k);
      if (rr_sum >= NUM_IN_X) begin
        rr_sum = rr_sum - NUM_IN_X;
      end
      rr_cand = rr_sum[SEL_W-1:0];
      if (!rr_found && in_valid[rr_cand]) begin
        rr_found = 1'b1;
        rr_idx   = rr_cand;
      end
    end
  end

  // Pick the grant source according to the live mode input.
  always_comb begin
    grant_vld = 1'b0;
    grant     = '0;
    if (mode) begin
      grant_vld = rr_found;
      grant     = rr_idx;
    end else begin
      grant_vld = sel_hit;
      grant     = sel;
    end
  end

  // The output register can take a word when empty or when its word leaves this cycle.
  always_comb begin
    can_accept = ~out_valid_q | out_ready;
    in_xfer    = rst_n & can_accept & grant_vld;
  end

  // One-hot accept toward the granted channel only; all low in reset or while stalled.
  always_comb begin
    in_ready = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      in_ready[i] = in_xfer && (grant == SEL_W'(i));
    end
  end

  // Next-state: load on accept (overwriting a draining word), clear valid on a bare drain.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_src_d    = out_src_q;
    last_grant_d = last_grant_q;
    if (in_xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = in_word[grant];
      out_src_d   = grant;
      if (mode) begin
        last_grant_d = grant;
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Output register and RR pointer; reset drops any held word immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_src_q    <= '0;
      last_grant_q <= LAST_IDX;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_src_q    <= out_src_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Self-checking bench for stream_mux_rr: directed scenarios plus randomized traffic.
// Reference model tracks the held word, its source and the RR pointer at transaction level.
// Inputs change on the falling edge; all DUT observations are taken 1 time unit later.
module tb_stream_mux_rr;

  localparam int WIDTH  = 64;
  localparam int NUM_IN = 4;
  localparam int SEL_W  = 2;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic [NUM_IN-1:0]       in_valid = '0;
  logic [NUM_IN-1:0]       in_ready;
  logic [NUM_IN*WIDTH-1:0] in_data = '0;
  logic [SEL_W-1:0]        sel = '0;
  logic                    mode = 1'b0;
  logic                    out_valid;
  logic                    out_ready = 1'b0;
  logic [WIDTH-1:0]        out_data;
  logic [SEL_W-1:0]        out_src;

  stream_mux_rr #(.WIDTH(WIDTH), .NUM_IN(NUM_IN)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .sel       (sel),
    .mode      (mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_src   (out_src)
  );

  always #5 clk = ~clk;

  // Reference model state.
  bit          m_valid;
  logic [63:0] m_data;
  int          m_src;
  int          m_last;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [3:0]  obs_ready;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] word_of(input logic [255:0] d, input int i);
    return d[i*WIDTH +: WIDTH];
  endfunction

  function automatic logic [255:0] rand_data();
    logic [255:0] d;
    for (int i = 0; i < NUM_IN; i++) d[i*WIDTH +: WIDTH] = {$urandom, $urandom};
    return d;
  endfunction

  // One clock: drive at negedge, compare against the model, advance the model, wait for posedge.
  task automatic cycle(input logic [3:0] v, input logic [255:0] d, input logic [1:0] s,
                       input logic m, input logic ordy, input logic rn);
    int         g;
    bit         g_ok;
    logic [3:0] exp_rdy;
    @(negedge clk);
    in_valid  = v;
    in_data   = d;
    sel       = s;
    mode      = m;
    out_ready = ordy;
    rst_n     = rn;
    #1;
    if (!rn) begin
      m_valid = 1'b0;
      m_data  = '0;
      m_src   = 0;
      m_last  = NUM_IN - 1;
    end
    g_ok = 1'b0;
    g    = 0;
    if (!m) begin
      if (int'(s) < NUM_IN && ((v >> s) & 4'd1) != 4'd0) begin
        g_ok = 1'b1;
        g    = int'(s);
      end
    end else begin
      for (int k = 1; k <= NUM_IN; k++) begin
        int c;
        c = (m_last + k) % NUM_IN;
        if (!g_ok && ((v >> c) & 4'd1) != 4'd0) begin
          g_ok = 1'b1;
          g    = c;
        end
      end
    end
    exp_rdy   = (rn && (!m_valid || ordy) && g_ok) ? 4'(1 << g) : 4'b0000;
    obs_ready = in_ready;
    check_eq("in_ready",  64'(in_ready),  64'(exp_rdy));
    check_eq("out_valid", 64'(out_valid), 64'(m_valid));
    check_eq("out_data",  out_data,       m_data);
    check_eq("out_src",   64'(out_src),   64'(m_src));
    if (rn) begin
      if (exp_rdy != 4'b0000) begin
        m_valid = 1'b1;
        m_data  = word_of(d, g);
        m_src   = g;
        if (m) m_last = g;
      end else if (m_valid && ordy) begin
        m_valid = 1'b0;
      end
    end
    @(posedge clk);
  endtask

  // Constant expectations on the registered outputs just after the edge.
  task automatic check_out(input string tag, input logic v, input logic [63:0] d, input logic [1:0] s);
    #1;
    check_eq({tag, "_valid"}, 64'(out_valid), 64'(v));
    if (v) begin
      check_eq({tag, "_data"}, out_data, d);
      check_eq({tag, "_src"}, 64'(out_src), 64'(s));
    end
  endtask

  initial begin
    logic [255:0] d;
    logic [63:0]  w;
    m_valid = 1'b0;
    m_data  = '0;
    m_src   = 0;
    m_last  = NUM_IN - 1;

    // Reset held with every channel valid: nothing accepted, outputs cleared.
    d = rand_data();
    repeat (3) cycle(4'hF, d, 2'd2, 1'b0, 1'b1, 1'b0);
    check_eq("rst_in_ready", 64'(obs_ready), 64'h0);

    // Release with downstream blocked: exactly one word, then a stall.
    cycle(4'hF, d, 2'd0, 1'b1, 1'b0, 1'b1);
    check_eq("release_first_rdy", 64'(obs_ready), 64'h1);
    cycle(4'hF, d, 2'd0, 1'b1, 1'b0, 1'b1);
    check_eq("release_stall_rdy", 64'(obs_ready), 64'h0);
    check_out("release", 1'b1, word_of(d, 0), 2'd0);

    // Explicit select of channel 2 while the held word drains on the same edge.
    d = rand_data();
    d[2*WIDTH +: WIDTH] = 64'h123456789ABCDEF0;
    cycle(4'hF, d, 2'd2, 1'b0, 1'b1, 1'b1);
    check_eq("explicit_rdy", 64'(obs_ready), 64'h4);
    check_out("explicit", 1'b1, 64'h123456789ABCDEF0, 2'd2);

    // Explicit select of an idle channel: no accept, held word drains.
    cycle(4'b1101, d, 2'd1, 1'b0, 1'b1, 1'b1);
    check_eq("idle_sel_rdy", 64'(obs_ready), 64'h0);
    check_out("idle_sel", 1'b0, 64'h0, 2'd0);

    // Fairness after a fresh reset: sources rotate 0,1,2,3,0,1,2,3.
    cycle(4'h0, d, 2'd0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      d = rand_data();
      w = word_of(d, i % NUM_IN);
      cycle(4'hF, d, 2'd0, 1'b1, 1'b1, 1'b1);
      check_out("fair", 1'b1, w, 2'(i % NUM_IN));
    end

    // Skip and wrap: park pointer at 2, then only channel 1 valid, then channels 0 and 3.
    d = rand_data();
    cycle(4'b0100, d, 2'd0, 1'b1, 1'b1, 1'b1);
    check_eq("rr_park2_rdy", 64'(obs_ready), 64'h4);
    cycle(4'b0010, d, 2'd0, 1'b1, 1'b1, 1'b1);
    check_eq("rr_wrap_rdy", 64'(obs_ready), 64'h2);
    cycle(4'b1001, d, 2'd0, 1'b1, 1'b1, 1'b1);
    check_eq("rr_skip_rdy", 64'(obs_ready), 64'h8);
    check_out("rr_skip", 1'b1, word_of(d, 3), 2'd3);

    // Backpressure: hold A5 pattern for five stalled cycles with churning inputs.
    d = rand_data();
    d[0 +: WIDTH] = 64'hA5A5A5A5A5A5A5A5;
    cycle(4'b0001, d, 2'd0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      cycle(4'($urandom), rand_data(), 2'($urandom), 1'($urandom), 1'b0, 1'b1);
      check_eq("stall_rdy", 64'(obs_ready), 64'h0);
      check_out("stall", 1'b1, 64'hA5A5A5A5A5A5A5A5, 2'd0);
    end
    d = rand_data();
    w = word_of(d, 1);
    cycle(4'b0010, d, 2'd1, 1'b0, 1'b1, 1'b1);
    check_eq("unstall_rdy", 64'(obs_ready), 64'h2);
    check_out("unstall", 1'b1, w, 2'd1);
    cycle(4'hF, d, 2'd0, 1'b0, 1'b0, 1'b1);
    check_out("restall", 1'b1, w, 2'd1);
    cycle(4'hF, d, 2'd0, 1'b0, 1'b0, 1'b0);
    check_out("rst_mid_stall", 1'b0, 64'h0, 2'd0);

    // Randomized traffic against the model, with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      cycle(4'($urandom), rand_data(), 2'($urandom), 1'($urandom),
            1'(($urandom % 4) != 0), 1'(($urandom % 64) != 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
